// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the 8-bit registered ALU: buffers op commands in a FIFO,
// issues each one to the ALU for a single cycle and returns the captured result.
package alu_cmd_driver_pkg;
   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   localparam logic [3:0] OP_HOLD = 4'hF;
endpackage

module alu_cmd_driver
   import alu_cmd_driver_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [3:0] rsp_op,
   output logic       rsp_zero,
   output logic       busy,
   output logic [7:0] alu_in1,
   output logic [7:0] alu_in2,
   output logic [3:0] alu_op,
   output logic       alu_rst,
   input  logic [7:0] alu_out
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

   state_t        state, state_nxt;
   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CW-1:0] count, count_nxt;
   logic          push_c, pop_c;
   logic          cmd_ready_nxt, busy_nxt;
   logic          rsp_valid_nxt, rsp_zero_nxt, alu_rst_nxt;
   logic [7:0]    rsp_data_nxt, alu_in1_nxt, alu_in2_nxt;
   logic [3:0]    rsp_op_nxt, alu_op_nxt;

   assign head = mem[rd_ptr];

   // Next-state and next-output logic; the ALU is held (op 15) outside ISSUE.
   always_comb begin
      state_nxt     = state;
      push_c        = cmd_valid & cmd_ready;
      pop_c         = 1'b0;
      alu_in1_nxt   = alu_in1;
      alu_in2_nxt   = alu_in2;
      alu_op_nxt    = OP_HOLD;
      alu_rst_nxt   = 1'b0;
      rsp_valid_nxt = rsp_valid;
      rsp_data_nxt  = rsp_data;
      rsp_op_nxt    = rsp_op;
      rsp_zero_nxt  = rsp_zero;

      case (state)
         IDLE: begin
            if (count != '0) begin
               pop_c       = 1'b1;
               alu_in1_nxt = head.a;
               alu_in2_nxt = head.b;
               rsp_op_nxt  = head.op;
               // CLEAR is a one-cycle ALU reset pulse rather than a live opcode
               if (head.op == OP_HOLD) alu_rst_nxt = 1'b1;
               else                    alu_op_nxt  = head.op;
               state_nxt   = ISSUE;
            end
         end
         ISSUE: state_nxt = CAPT;
         CAPT: begin
            rsp_data_nxt  = alu_out;
            rsp_zero_nxt  = (alu_out == 8'h00);
            rsp_valid_nxt = 1'b1;
            state_nxt     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      wr_ptr_nxt    = push_c ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr_nxt    = pop_c  ? rd_ptr + PW'(1) : rd_ptr;
      count_nxt     = count + CW'(push_c) - CW'(pop_c);
      cmd_ready_nxt = (count_nxt != CW'(DEPTH));
      busy_nxt      = (state_nxt != IDLE) || (count_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
         rsp_op    <= 4'h0;
         rsp_zero  <= 1'b0;
         alu_in1   <= 8'h00;
         alu_in2   <= 8'h00;
         alu_op    <= OP_HOLD;
         alu_rst   <= 1'b1;
      end else begin
         state     <= state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         count     <= count_nxt;
         cmd_ready <= cmd_ready_nxt;
         busy      <= busy_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
         rsp_op    <= rsp_op_nxt;
         rsp_zero  <= rsp_zero_nxt;
         alu_in1   <= alu_in1_nxt;
         alu_in2   <= alu_in2_nxt;
         alu_op    <= alu_op_nxt;
         alu_rst   <= alu_rst_nxt;
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
   end
endmodule
